// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared types and helpers for the GPIO block (gpio_ctrl / gpio_debounce).
//   led_mode_t : per-LED drive mode as presented by the CSR hwif field
//   LED_MODE_W : width of one led_mode_t field inside the packed led_mode bus
//   polarity() : converts between "asserted" (1 = pressed / lit) and pin level
// -----------------------------------------------------------------------------
package gpio_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int LED_MODE_W = 2;

    // The mapping is its own inverse, so the same helper normalises a key pin
    // and drives an LED pin.
    function automatic logic polarity(input logic value, input logic active_low);
        return value ^ active_low;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One key input: two-flop synchroniser, stability counter, press/release pulses.
// Parameters:
//   DEB_CYCLES     consecutive differing cycles before a change is accepted (>=1)
//   KEY_ACTIVE_LOW 1: a pressed key reads 0 at the pin
// Ports:
//   clk          in   system clock
//   arst_n       in   asynchronous reset, active low
//   key_pin      in   raw key pin (asynchronous to clk)
//   key_level    out  debounced state, 1 = pressed
//   key_press    out  1-cycle pulse when a press is accepted
//   key_release  out  1-cycle pulse when a release is accepted
// Latency from a clean pin edge to key_level is 2 + DEB_CYCLES cycles.
// -----------------------------------------------------------------------------
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEB_CYCLES     = 500000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic key_pin,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             key_s;
    logic [CNT_W-1:0] cnt;

    // Synchronised sample, normalised so that 1 means pressed.
    assign key_s = polarity(sync2, KEY_ACTIVE_LOW);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // Sync flops start at the idle pin level so reset never looks like a press.
            sync1       <= KEY_ACTIVE_LOW;
            sync2       <= KEY_ACTIVE_LOW;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_pin;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (key_s == key_level) begin
                // Any agreeing sample restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_level   <= key_s;
                key_press   <= key_s;
                key_release <= ~key_s;
                cnt         <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl
// GPIO block between board key/LED pins and the CSR hwif, clocked on sys_clk.
// Keys are debounced per key (gpio_debounce); LEDs are driven OFF/ON/BLINK/PWM
// from a shared blink counter and a shared free-running PWM counter.
// Optional feature macro: GPIO_IRQ_EN
//   defined     : sticky per-key press flags (key_pending) and a level irq
//   not defined : key_pending and irq tied to 0, irq_en/irq_clr ignored
// Ports:
//   clk          in   system clock
//   arst_n       in   asynchronous reset, active low
//   key_in       in   raw key pins [NUM_KEYS]
//   led          out  LED pins [NUM_LEDS], registered
//   led_mode     in   per-LED led_mode_t [2*NUM_LEDS]
//   led_duty     in   per-LED PWM duty [PWM_W*NUM_LEDS]
//   blink_half   in   blink half-period in cycles, minus 1
//   key_level    out  debounced key state, 1 = pressed
//   key_press    out  1-cycle pulse on accepted press
//   key_release  out  1-cycle pulse on accepted release
//   irq_en       in   per-key interrupt enable
//   irq_clr      in   per-key write-1-to-clear pulse for key_pending
//   key_pending  out  sticky press flags
//   irq          out  |(key_pending & irq_en), combinational from registers
// -----------------------------------------------------------------------------
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int NUM_LEDS       = 2,
    parameter int DEB_CYCLES     = 500000,
    parameter int BLINK_DIV_W    = 24,
    parameter int PWM_W          = 8,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_KEYS-1:0]       key_in,
    output logic [NUM_LEDS-1:0]       led,
    input  logic [2*NUM_LEDS-1:0]     led_mode,
    input  logic [PWM_W*NUM_LEDS-1:0] led_duty,
    input  logic [BLINK_DIV_W-1:0]    blink_half,
    output logic [NUM_KEYS-1:0]       key_level,
    output logic [NUM_KEYS-1:0]       key_press,
    output logic [NUM_KEYS-1:0]       key_release,
    input  logic [NUM_KEYS-1:0]       irq_en,
    input  logic [NUM_KEYS-1:0]       irq_clr,
    output logic [NUM_KEYS-1:0]       key_pending,
    output logic                      irq
);

    // ---------------------------------------------------------------- keys
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        gpio_debounce #(
            .DEB_CYCLES     (DEB_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_deb (
            .clk         (clk),
            .arst_n      (arst_n),
            .key_pin     (key_in[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g])
        );
    end

    // ---------------------------------------------------------------- blink
    logic [BLINK_DIV_W-1:0] blink_cnt;
    logic                   blink_phase;

    // ">=" rather than "==" so that lowering blink_half below the running
    // count wraps on the next cycle instead of running the counter round.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt >= blink_half) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- pwm
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- leds
    logic [NUM_LEDS-1:0] led_lit;

    always_comb begin
        led_lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (led_mode[LED_MODE_W*i +: LED_MODE_W])
                LED_OFF:   led_lit[i] = 1'b0;
                LED_ON:    led_lit[i] = 1'b1;
                LED_BLINK: led_lit[i] = blink_phase;
                LED_PWM:   led_lit[i] = (pwm_cnt < led_duty[PWM_W*i +: PWM_W]);
                default:   led_lit[i] = 1'b0;
            endcase
        end
    end

    // Polarity is applied here so the pin register holds the true pin level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            led <= {NUM_LEDS{LED_ACTIVE_LOW}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led[i] <= polarity(led_lit[i], LED_ACTIVE_LOW);
            end
        end
    end

    // ---------------------------------------------------------------- irq
`ifdef GPIO_IRQ_EN
    logic [NUM_KEYS-1:0] pending_q;

    // A press arriving in the same cycle as a clear must not be lost.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~irq_clr) | key_press;
        end
    end

    assign key_pending = pending_q;
    assign irq         = |(pending_q & irq_en);
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_en, irq_clr};
    assign key_pending       = '0;
    assign irq               = 1'b0;
`endif

endmodule
